time_display: RTL and testbench

Downstream consumer of the 0.1 s game counter. It captures the 10-bit tenths count on each update pulse and converts it to four BCD digits with a sequential shift-add-3 engine. It drives four active-low seven-segment displays (HEX3..HEX0, reading "SSS.t") and holds a split time latched on the counter block's write strobe.

---
 rtl/time_display.sv | 135 +++++++++++++
 tb/tb_time_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_display.sv
// Converts the game counter's tenths count to BCD with a sequential shift-add-3 engine.
// Drives four active-low seven-segment digits reading "SSS.t" and can show a latched split time.
module time_display (
  input  logic        CLOCK50M,
  input  logic        KEY1,
  input  logic [9:0]  counter_in,
  input  logic        counter_update,
  input  logic        split,
  input  logic        show_split,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]  state;
  logic [25:0] shift_reg;
  logic [3:0]  iter;
  logic        pending;
  logic [9:0]  pending_val;
  logic [15:0] split_bcd;
  logic [15:0] display_src;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // An update arriving while busy is parked one-deep; the latest one wins.
  always_ff @(posedge CLOCK50M or negedge KEY1) begin
    if (!KEY1) begin
      state       <= IDLE;
      busy        <= 1'b0;
      shift_reg   <= 26'd0;
      iter        <= 4'd0;
      pending     <= 1'b0;
      pending_val <= 10'd0;
      bcd_out     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (counter_update) begin
            shift_reg <= {16'h0000, counter_in};
            iter      <= 4'd0;
            pending   <= 1'b0;
            state     <= CONV;
            busy      <= 1'b1;
          end else if (pending) begin
            shift_reg <= {16'h0000, pending_val};
            iter      <= 4'd0;
            pending   <= 1'b0;
            state     <= CONV;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          shift_reg <= {add3_nibbles(shift_reg[25:10]), shift_reg[9:0]} << 1;
          iter      <= iter + 4'd1;
          if (iter == 4'd9) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_out <= shift_reg[25:10];
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (state != IDLE && counter_update) begin
        pending_val <= counter_in;
        pending     <= 1'b1;
      end
    end
  end

  always_comb begin
    display_src = show_split ? split_bcd : bcd_out;
  end

  // Split captures the committed value from before the edge, so a same-edge commit is missed.
  always_ff @(posedge CLOCK50M or negedge KEY1) begin
    if (!KEY1) begin
      split_bcd <= 16'h0000;
      HEX3      <= 7'b1111111;
      HEX2      <= 7'b1111111;
      HEX1      <= 7'b1000000;
      HEX0      <= 7'b1000000;
    end else begin
      if (split) begin
        split_bcd <= bcd_out;
      end
      HEX3 <= (display_src[15:12] == 4'd0) ? 7'b1111111 : seg7(display_src[15:12]);
      HEX2 <= (display_src[15:12] == 4'd0 && display_src[11:8] == 4'd0) ?
              7'b1111111 : seg7(display_src[11:8]);
      HEX1 <= seg7(display_src[7:4]);
      HEX0 <= seg7(display_src[3:0]);
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_time_display;

  logic        CLOCK50M = 1'b0;
  logic        KEY1 = 1'b0;
  logic [9:0]  counter_in = 10'd0;
  logic        counter_update = 1'b0;
  logic        split = 1'b0;
  logic        show_split = 1'b0;
  logic [15:0] bcd_out;
  logic        busy;
  logic [6:0]  HEX3, HEX2, HEX1, HEX0;

  int checks = 0;
  int fails = 0;
  bit saw_0101 = 1'b0;

  // Reference model state: cycles since conversion start (0 = idle), pending slot, outputs.
  int          m_phase = 0;
  int          m_val = 0;
  bit          m_pend = 1'b0;
  int          m_pend_val = 0;
  logic [15:0] m_bcd = 16'h0000;
  logic [15:0] m_split = 16'h0000;
  logic [27:0] m_hex = {7'h7F, 7'h7F, 7'b1000000, 7'b1000000};

  time_display dut (
    .CLOCK50M       (CLOCK50M),
    .KEY1           (KEY1),
    .counter_in     (counter_in),
    .counter_update (counter_update),
    .split          (split),
    .show_split     (show_split),
    .bcd_out        (bcd_out),
    .busy           (busy),
    .HEX3           (HEX3),
    .HEX2           (HEX2),
    .HEX1           (HEX1),
    .HEX0           (HEX0)
  );

  always #10 CLOCK50M = ~CLOCK50M;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [27:0] hex_of(input logic [15:0] b);
    int d3, d2, d1, d0;
    logic [6:0] h3, h2;
    d3 = int'(b[15:12]);
    d2 = int'(b[11:8]);
    d1 = int'(b[7:4]);
    d0 = int'(b[3:0]);
    h3 = (d3 == 0) ? 7'h7F : seg_of(d3);
    h2 = (d3 == 0 && d2 == 0) ? 7'h7F : seg_of(d2);
    return {h3, h2, seg_of(d1), seg_of(d0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge CLOCK50M or negedge KEY1) begin
    if (!KEY1) begin
      m_phase    = 0;
      m_pend     = 1'b0;
      m_pend_val = 0;
      m_bcd      = 16'h0000;
      m_split    = 16'h0000;
      m_hex      = hex_of(16'h0000);
    end else begin
      m_hex = hex_of(show_split ? m_split : m_bcd);
      if (split) m_split = m_bcd;
      if (m_phase != 0 && counter_update) begin
        m_pend     = 1'b1;
        m_pend_val = int'(counter_in);
      end
      if (m_phase == 0) begin
        if (counter_update) begin
          m_val   = int'(counter_in);
          m_phase = 1;
          m_pend  = 1'b0;
        end else if (m_pend) begin
          m_val   = m_pend_val;
          m_phase = 1;
          m_pend  = 1'b0;
        end
      end else if (m_phase == 11) begin
        m_bcd   = to_bcd(m_val);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, just after each rising edge.
  always begin
    @(posedge CLOCK50M);
    #1;
    checkOutput("bcd_out", {16'h0, bcd_out}, {16'h0, m_bcd});
    checkOutput("busy", {31'h0, busy}, {31'h0, (m_phase != 0)});
    checkOutput("hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, m_hex});
    if (bcd_out == 16'h0101) saw_0101 = 1'b1;
  end

  // Called at a falling edge; the pulse is sampled at the next rising edge E, returns at E + half.
  task automatic applyStimulus(input logic [9:0] v);
    counter_in     = v;
    counter_update = 1'b1;
    @(negedge CLOCK50M);
    counter_update = 1'b0;
  endtask

  task automatic checkHex(input string name, input logic [6:0] h3, input logic [6:0] h2,
                          input logic [6:0] h1, input logic [6:0] h0);
    checkOutput({name, "_hex3"}, {25'h0, HEX3}, {25'h0, h3});
    checkOutput({name, "_hex2"}, {25'h0, HEX2}, {25'h0, h2});
    checkOutput({name, "_hex1"}, {25'h0, HEX1}, {25'h0, h1});
    checkOutput({name, "_hex0"}, {25'h0, HEX0}, {25'h0, h0});
  endtask

  initial begin
    repeat (3) @(negedge CLOCK50M);
    checkOutput("reset_bcd", {16'h0, bcd_out}, 32'h0000);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkHex("reset", 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000);
    KEY1 = 1'b1;
    @(negedge CLOCK50M);

    applyStimulus(10'd1023);
    checkOutput("busy_after_E", {31'h0, busy}, 32'h1);
    repeat (10) @(negedge CLOCK50M);
    checkOutput("bcd_before_commit", {16'h0, bcd_out}, 32'h0000);
    @(negedge CLOCK50M);
    checkOutput("bcd_1023", {16'h0, bcd_out}, 32'h1023);
    checkOutput("busy_after_commit", {31'h0, busy}, 32'h0);
    @(negedge CLOCK50M);
    checkHex("h1023", 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000);

    applyStimulus(10'd57);
    repeat (11) @(negedge CLOCK50M);
    checkOutput("bcd_57", {16'h0, bcd_out}, 32'h0057);
    @(negedge CLOCK50M);
    checkHex("h57", 7'b1111111, 7'b1111111, 7'b0010010, 7'b1111000);

    applyStimulus(10'd100);
    repeat (12) @(negedge CLOCK50M);
    checkHex("h100", 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000);

    applyStimulus(10'd57);
    repeat (12) @(negedge CLOCK50M);
    split = 1'b1;
    @(negedge CLOCK50M);
    split = 1'b0;
    applyStimulus(10'd123);
    repeat (12) @(negedge CLOCK50M);
    checkOutput("bcd_123", {16'h0, bcd_out}, 32'h0123);
    show_split = 1'b1;
    @(negedge CLOCK50M);
    checkHex("split_on", 7'b1111111, 7'b1111111, 7'b0010010, 7'b1111000);
    show_split = 1'b0;
    @(negedge CLOCK50M);
    checkHex("split_off", 7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000);

    applyStimulus(10'd100);
    @(negedge CLOCK50M);
    applyStimulus(10'd101);
    repeat (2) @(negedge CLOCK50M);
    applyStimulus(10'd102);
    repeat (6) @(negedge CLOCK50M);
    checkOutput("overlap_first", {16'h0, bcd_out}, 32'h0100);
    repeat (11) @(negedge CLOCK50M);
    checkOutput("overlap_before_second", {16'h0, bcd_out}, 32'h0100);
    @(negedge CLOCK50M);
    checkOutput("overlap_second", {16'h0, bcd_out}, 32'h0102);
    checkOutput("never_0101", {31'h0, saw_0101}, 32'h0);

    applyStimulus(10'd500);
    repeat (4) @(negedge CLOCK50M);
    KEY1 = 1'b0;
    #1;
    checkOutput("midreset_bcd", {16'h0, bcd_out}, 32'h0000);
    checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
    checkHex("midreset", 7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000);
    @(negedge CLOCK50M);
    KEY1 = 1'b1;
    @(negedge CLOCK50M);
    applyStimulus(10'd9);
    repeat (11) @(negedge CLOCK50M);
    checkOutput("bcd_9", {16'h0, bcd_out}, 32'h0009);
    checkOutput("busy_idle_9", {31'h0, busy}, 32'h0);
    @(negedge CLOCK50M);
    checkHex("h9", 7'b1111111, 7'b1111111, 7'b1000000, 7'b0010000);
    repeat (20) @(negedge CLOCK50M);
    checkOutput("stable_9", {16'h0, bcd_out}, 32'h0009);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
